// File: rtl/score4_pkg.sv
// rtl/score4_pkg.sv - shared board dimensions, cell/status/state types for the Score 4 board
package score4_pkg;

  localparam int COLS      = 7;
  localparam int ROWS      = 6;
  localparam int MAX_MOVES = 42;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_COL_FULL = 2'b01,
    ST_BAD_COL  = 2'b10,
    ST_AUTO     = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CHECK = 2'b01,
    S_OVER  = 2'b10
  } state_t;

  // Token code for the player whose turn it is (0 = red, 1 = green)
  function automatic cell_t player_cell(input logic player);
    return player ? GREEN : RED;
  endfunction

endpackage

// File: rtl/score4_board_column_drop.sv
// rtl/score4_board_column_drop.sv - gravity helper: full flag and landing row for one column
module column_drop
  import score4_pkg::*;
(
  input  logic [ROWS-1:0][1:0] cells,
  output logic                 full,
  output logic [2:0]           row
);

  // Row 5 is the bottom; the landing row is the highest-index empty cell
  always_comb begin
    full = (cells[0] != EMPTY);
    row  = 3'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (cells[r] == EMPTY) row = 3'(r);
    end
  end

endmodule

// File: rtl/score4_board.sv
// rtl/score4_board.sv - Score 4 board writer; optional idle auto-move under SCORE4_MOVE_TIMER_EN
module score4_board
  import score4_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      new_game,
  input  logic                      move_valid,
  input  logic [2:0]                move_col,
  output logic                      move_ready,
  input  logic                      win_exists,
  input  logic                      win_player,
  output logic [COLS-1:0][ROWS-1:0][1:0] panel,
  output logic                      turn,
  output logic                      done,
  output logic [1:0]                status,
  output logic                      game_over,
  output logic                      winner,
  output logic                      draw
);

  state_t     state, state_nxt;
  status_t    status_q;
  logic [5:0] move_cnt;
  logic       auto_q;

  logic       accept, bad_col, legal, fire;
  logic [2:0] mc_idx, mc_row, wr_col, wr_row;
  logic       mc_full;

  assign accept  = (state == S_IDLE) && move_valid && !new_game;
  assign bad_col = (move_col > 3'd6);
  assign mc_idx  = bad_col ? 3'd0 : move_col;
  assign status  = status_q;

  column_drop u_sel_drop (
    .cells (panel[mc_idx]),
    .full  (mc_full),
    .row   (mc_row)
  );

`ifdef SCORE4_MOVE_TIMER_EN
  localparam int             IW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  logic [IW-1:0]   idle_cnt;
  logic [COLS-1:0] col_full;
  logic [2:0]      scan_row [COLS];
  logic [2:0]      auto_col;

  for (genvar c = 0; c < COLS; c++) begin : g_scan
    column_drop u_scan_drop (
      .cells (panel[c]),
      .full  (col_full[c]),
      .row   (scan_row[c])
    );
  end

  // Lowest-index column that still has room
  always_comb begin
    auto_col = 3'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_full[c]) auto_col = 3'(c);
    end
  end

  // A same-cycle handshake always beats the timeout
  assign fire   = (state == S_IDLE) && !new_game && !move_valid && (idle_cnt == IDLE_LAST);
  assign wr_col = fire ? auto_col : move_col;
  assign wr_row = fire ? scan_row[auto_col] : mc_row;

  // Idle counter only advances while waiting for a move in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (new_game || state != S_IDLE || accept || fire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end
`else
  assign fire   = 1'b0;
  assign wr_col = move_col;
  assign wr_row = mc_row;
`endif

  assign legal = (accept && !bad_col && !mc_full) || fire;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (legal) state_nxt = S_CHECK;
        S_CHECK: state_nxt = (win_exists || move_cnt == 6'(MAX_MOVES)) ? S_OVER : S_IDLE;
        S_OVER:  state_nxt = S_OVER;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    move_ready = (state == S_IDLE);
    game_over  = (state == S_OVER);
  end

  // Board, turn, move count and completion reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      panel    <= '0;
      turn     <= 1'b0;
      move_cnt <= 6'd0;
      auto_q   <= 1'b0;
      done     <= 1'b0;
      status_q <= ST_OK;
      winner   <= 1'b0;
      draw     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (new_game) begin
        panel    <= '0;
        turn     <= 1'b0;
        move_cnt <= 6'd0;
        auto_q   <= 1'b0;
        winner   <= 1'b0;
        draw     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept && bad_col) begin
              done     <= 1'b1;
              status_q <= ST_BAD_COL;
            end else if (accept && mc_full) begin
              done     <= 1'b1;
              status_q <= ST_COL_FULL;
            end else if (legal) begin
              panel[wr_col][wr_row] <= player_cell(turn);
              turn     <= ~turn;
              move_cnt <= move_cnt + 6'd1;
              auto_q   <= fire;
            end
          end
          S_CHECK: begin
            done     <= 1'b1;
            status_q <= auto_q ? ST_AUTO : ST_OK;
            if (win_exists)                       winner <= win_player;
            else if (move_cnt == 6'(MAX_MOVES))   draw   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score4_board.sv
// tb/tb_score4_board.sv - self-checking bench for score4_board with a board-level reference model
module tb_score4_board;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic new_game = 1'b0;
  logic move_valid = 1'b0;
  logic [2:0] move_col = 3'd0;
  logic win_exists = 1'b0;
  logic win_player = 1'b0;
  logic [6:0][5:0][1:0] panel;
  logic turn, move_ready, done, game_over, winner, draw;
  logic [1:0] status;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  score4_board #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_col   (move_col),
    .move_ready (move_ready),
    .win_exists (win_exists),
    .win_player (win_player),
    .panel      (panel),
    .turn       (turn),
    .done       (done),
    .status     (status),
    .game_over  (game_over),
    .winner     (winner),
    .draw       (draw)
  );

  // Reference model: column heights and a cell grid, advanced once per clock
  logic [1:0] m_cell [7][6];
  int         m_h [7];
  logic       m_turn, m_done, m_winner, m_draw, m_checking, m_locked, m_auto;
  logic [1:0] m_status;
  int         m_moves, m_idle;

  task m_clear();
    for (int c = 0; c < 7; c++) begin
      m_h[c] = 0;
      for (int r = 0; r < 6; r++) m_cell[c][r] = 2'b00;
    end
    m_turn = 0; m_done = 0; m_winner = 0; m_draw = 0;
    m_checking = 0; m_locked = 0; m_auto = 0; m_moves = 0; m_idle = 0;
  endtask

  task m_place(input int col, input logic is_auto);
    m_cell[col][5 - m_h[col]] = m_turn ? 2'b10 : 2'b01;
    m_h[col]   = m_h[col] + 1;
    m_turn     = ~m_turn;
    m_moves    = m_moves + 1;
    m_checking = 1;
    m_auto     = is_auto;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clear();
      m_status = 2'b00;
    end else begin
      m_done = 0;
      if (new_game) begin
        m_clear();
      end else if (m_checking) begin
        m_done = 1;
        m_status = m_auto ? 2'b11 : 2'b00;
        m_checking = 0;
        if (win_exists) begin
          m_locked = 1; m_winner = win_player;
        end else if (m_moves == 42) begin
          m_locked = 1; m_draw = 1;
        end
      end else if (!m_locked) begin
        if (move_valid) begin
          m_idle = 0;
          if (move_col > 6) begin
            m_done = 1; m_status = 2'b10;
          end else if (m_h[move_col] == 6) begin
            m_done = 1; m_status = 2'b01;
          end else begin
            m_place(int'(move_col), 1'b0);
          end
        end else begin
`ifdef SCORE4_MOVE_TIMER_EN
          if (m_idle == TO - 1) begin
            int ac;
            ac = 0;
            for (int c = 6; c >= 0; c--) if (m_h[c] < 6) ac = c;
            m_place(ac, 1'b1);
            m_idle = 0;
          end else begin
            m_idle = m_idle + 1;
          end
`endif
        end
      end
      if (m_checking || m_locked) m_idle = 0;
    end
  end

  function automatic logic [83:0] model_panel();
    logic [6:0][5:0][1:0] p;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) p[c][r] = m_cell[c][r];
    return p;
  endfunction

  task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_panel", panel, model_panel());
      chk("m_turn", 84'(turn), 84'(m_turn));
      chk("m_ready", 84'(move_ready), 84'(!m_checking && !m_locked));
      chk("m_done", 84'(done), 84'(m_done));
      chk("m_status", 84'(status), 84'(m_status));
      chk("m_over", 84'(game_over), 84'(m_locked));
      chk("m_winner", 84'(winner), 84'(m_winner));
      chk("m_draw", 84'(draw), 84'(m_draw));
    end
  end

  task automatic move(input logic [2:0] col);
    move_valid = 1'b1;
    move_col   = col;
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic legal_move(input logic [2:0] col);
    move(col);
    @(negedge clk);
  endtask

  task automatic ng();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_panel", panel, 84'd0);
    chk("rst_turn", 84'(turn), 84'd0);
    chk("rst_ready", 84'(move_ready), 84'd1);
    chk("rst_done", 84'(done), 84'd0);
    chk("rst_status", 84'(status), 84'd0);
    chk("rst_over", 84'({game_over, winner, draw}), 84'd0);
    rst_n = 1'b1;

    // First drop lands at the bottom of column 3
    move(3'd3);
    chk("t1_cell", 84'(panel[3][5]), 84'(2'b01));
    chk("t1_turn", 84'(turn), 84'd1);
    chk("t1_ready", 84'(move_ready), 84'd0);
    @(negedge clk);
    chk("t1_done", 84'({done, status}), 84'(3'b100));
    chk("t1_ready2", 84'(move_ready), 84'd1);

    // Stack column 0 to the top, then overflow it
    ng();
    chk("ng_panel", panel, 84'd0);
    chk("ng_turn", 84'(turn), 84'd0);
    for (int k = 0; k < 6; k++) legal_move(3'd0);
    chk("c0_stack", 84'(panel[0]), 84'(12'h666));
    move(3'd0);
    chk("c0_full", 84'({done, status}), 84'(3'b101));
    chk("c0_keep", 84'(panel[0]), 84'(12'h666));
    chk("c0_ready", 84'(move_ready), 84'd1);

    // Back-to-back out-of-range column
    move(3'd7);
    chk("bad_done", 84'({done, status}), 84'(3'b110));
    chk("bad_turn", 84'(turn), 84'd0);
    chk("bad_ready", 84'(move_ready), 84'd1);

    // Win reported by the checker locks the board
    win_exists = 1'b1;
    win_player = 1'b0;
    legal_move(3'd2);
    win_exists = 1'b0;
    chk("win_done", 84'({done, status}), 84'(3'b100));
    chk("win_over", 84'({game_over, winner, draw}), 84'(3'b100));
    move_valid = 1'b1;
    move_col   = 3'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("over_nodone", 84'(done), 84'd0);
    end
    move_valid = 1'b0;
    ng();
    chk("ng2_panel", panel, 84'd0);
    chk("ng2_state", 84'({turn, game_over}), 84'd0);

    // Reset in the middle of a move aborts it at once
    move(3'd5);
    rst_n = 1'b0;
    #1;
    chk("arst_panel", panel, 84'd0);
    chk("arst_turn", 84'(turn), 84'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole board with no winner
    for (int c = 0; c < 7; c++)
      for (int k = 0; k < 6; k++) begin
        win_player = k[0];
        legal_move(3'(c));
      end
    chk("draw_done", 84'({done, status}), 84'(3'b100));
    chk("draw_flags", 84'({game_over, draw}), 84'(2'b11));
    ng();

`ifdef SCORE4_MOVE_TIMER_EN
    // Idle timeout plays the first open column
    for (int k = 0; k < 6; k++) legal_move(3'd0);
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      chk("auto_seen", 84'(seen), 84'd1);
      chk("auto_status", 84'(status), 84'(2'b11));
      chk("auto_cell", 84'(panel[1][5]), 84'(2'b01));
    end
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
